// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the single-cycle ALU result (A) has priority
// over a FIFO of long-latency results (B), with an anti-starvation override.
module wb_write_arbiter #(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_rd,
  input  logic [XLEN-1:0]            a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_rd,
  input  logic [XLEN-1:0]            b_data,
  output logic                       wb_en,
  output logic [4:0]                 wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t          mem [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt, starve_nxt;
  logic             fifo_empty, force_b, push, pop;
  logic             wr_en_nxt, wr_sel_a;
  wb_ent_t          head;

  assign fifo_empty = (count == '0);
  assign force_b    = (starve_cnt == SMAX) && !fifo_empty;
  assign a_ready    = !force_b;
  assign b_ready    = (count < CW'(DEPTH));
  assign fifo_count = count;
  assign head       = mem[rd_ptr];
  // Writes to x0 are dropped at the door so they never occupy a slot.
  assign push       = b_valid && b_ready && (b_rd != 5'd0);

  always_comb begin
    pop        = 1'b0;
    wr_en_nxt  = 1'b0;
    wr_sel_a   = 1'b0;
    starve_nxt = starve_cnt;
    if (force_b) begin
      pop        = 1'b1;
      wr_en_nxt  = 1'b1;
      starve_nxt = '0;
    end else if (a_valid && (a_rd != 5'd0)) begin
      wr_en_nxt = 1'b1;
      wr_sel_a  = 1'b1;
      if (fifo_empty)              starve_nxt = '0;
      else if (starve_cnt != SMAX) starve_nxt = starve_cnt + 1'b1;
    end else if (a_valid) begin
      // A targeting x0 is swallowed; its slot goes to the FIFO head.
      pop       = !fifo_empty;
      wr_en_nxt = !fifo_empty;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      wr_en_nxt  = 1'b1;
      starve_nxt = '0;
    end else begin
      starve_nxt = '0;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_vld[i]) pending[mem[i].rd] = 1'b1;
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{rd: b_rd, data: b_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      slot_vld   <= '0;
      starve_cnt <= '0;
      wb_en      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      count      <= count + CW'(push) - CW'(pop);
      if (pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        slot_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr           <= wr_ptr + 1'b1;
        slot_vld[wr_ptr] <= 1'b1;
      end
      wb_en <= wr_en_nxt;
      if (wr_en_nxt) begin
        wb_rd   <= wr_sel_a ? a_rd   : head.rd;
        wb_data <= wr_sel_a ? a_data : head.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboarded bench for wb_write_arbiter; a second instance with a large
// starvation limit exercises the full-FIFO backpressure case.
module tb_wb_write_arbiter;
  localparam int XLEN = 64;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            a_valid = 0, b_valid = 0, a_ready, b_ready, wb_en;
  logic [4:0]      a_rd = 0, b_rd = 0, wb_rd;
  logic [XLEN-1:0] a_data = 0, b_data = 0, wb_data;
  logic [31:0]     pending;
  logic [2:0]      fifo_count;

  logic            a2_valid = 0, b2_valid = 0, a2_ready, b2_ready, wb2_en;
  logic [4:0]      a2_rd = 0, b2_rd = 0, wb2_rd;
  logic [XLEN-1:0] a2_data = 0, b2_data = 0, wb2_data;
  logic [31:0]     pending2;
  logic [2:0]      fifo_count2;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  exp_t q2[$];

  wb_write_arbiter #(.XLEN(XLEN), .DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending(pending), .fifo_count(fifo_count));

  wb_write_arbiter #(.XLEN(XLEN), .DEPTH(4), .STARVE_MAX(100)) dut2 (
    .clk(clk), .reset(reset),
    .a_valid(a2_valid), .a_ready(a2_ready), .a_rd(a2_rd), .a_data(a2_data),
    .b_valid(b2_valid), .b_ready(b2_ready), .b_rd(b2_rd), .b_data(b2_data),
    .wb_en(wb2_en), .wb_rd(wb2_rd), .wb_data(wb2_data),
    .pending(pending2), .fifo_count(fifo_count2));

  // Scoreboards: every registered write must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && wb_en) begin
      total++;
      if (q.size() == 0) begin
        bad++; $display("FAIL wb_unexpected got rd=%0d data=%0h want none", wb_rd, wb_data);
      end else begin
        e = q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          bad++; $display("FAIL wb_write got rd=%0d data=%0h want rd=%0d data=%0h", wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && wb2_en) begin
      total++;
      if (q2.size() == 0) begin
        bad++; $display("FAIL wb2_unexpected got rd=%0d data=%0h want none", wb2_rd, wb2_data);
      end else begin
        e = q2.pop_front();
        if (wb2_rd !== e.rd || wb2_data !== e.data) begin
          bad++; $display("FAIL wb2_write got rd=%0d data=%0h want rd=%0d data=%0h", wb2_rd, wb2_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic idle();
    a_valid = 0; b_valid = 0; a2_valid = 0; b2_valid = 0;
  endtask

  task automatic drive_a(input logic [4:0] rd, input logic [XLEN-1:0] d);
    a_valid = 1; a_rd = rd; a_data = d;
  endtask

  task automatic drive_b(input logic [4:0] rd, input logic [XLEN-1:0] d);
    b_valid = 1; b_rd = rd; b_data = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== '0) begin
      bad++; $display("FAIL reset_wb got en=%b rd=%0d data=%0h want 0", wb_en, wb_rd, wb_data);
    end
    total++;
    if (fifo_count !== 3'd0 || pending !== 32'd0) begin
      bad++; $display("FAIL reset_fifo got cnt=%0d pend=%h want 0", fifo_count, pending);
    end
    reset = 0;
    drive_a(5'd1, 64'h11); drive_b(5'd2, 64'h22); q.push_back('{5'd1, 64'h11});
    @(negedge clk);
    drive_a(5'd1, 64'h12); drive_b(5'd3, 64'h33); q.push_back('{5'd1, 64'h12});
    @(negedge clk);
    total++;
    if (fifo_count !== 3'd2 || pending !== 32'h0000_000C) begin
      bad++; $display("FAIL pre_reset_queue got cnt=%0d pend=%h want 2/0000000c", fifo_count, pending);
    end
    idle();
    #2 reset = 1;
    #1;
    total++;
    if (wb_en !== 1'b0 || fifo_count !== 3'd0 || pending !== 32'd0) begin
      bad++; $display("FAIL mid_reset got en=%b cnt=%0d pend=%h want 0/0/0", wb_en, fifo_count, pending);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (wb_en !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle cycle %0d got en=%b want 0", i, wb_en);
      end
    end
  endtask

  task automatic test_a_only();
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1) begin bad++; $display("FAIL a_ready_idle got %b want 1", a_ready); end
    drive_a(5'd5, 64'h1234); q.push_back('{5'd5, 64'h1234});
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1) begin bad++; $display("FAIL a_ready_after got %b want 1", a_ready); end
    idle();
    @(negedge clk);
    total++;
    if (wb_en !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 64'h1234) begin
      bad++; $display("FAIL wb_hold got en=%b rd=%0d data=%0h want 0/5/1234", wb_en, wb_rd, wb_data);
    end
  endtask

  task automatic test_b_only();
    @(negedge clk);
    drive_b(5'd7, 64'hAA); q.push_back('{5'd7, 64'hAA});
    @(negedge clk);
    total++;
    if (pending !== 32'h80 || fifo_count !== 3'd1) begin
      bad++; $display("FAIL b_queued got pend=%h cnt=%0d want 00000080/1", pending, fifo_count);
    end
    drive_b(5'd7, 64'hBB); q.push_back('{5'd7, 64'hBB});
    @(negedge clk);
    total++;
    if (pending !== 32'h80) begin bad++; $display("FAIL b_second_pending got %h want 00000080", pending); end
    idle();
    @(negedge clk);
    total++;
    if (pending !== 32'd0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL b_drained got pend=%h cnt=%0d want 0/0", pending, fifo_count);
    end
    @(negedge clk);
    total++;
    if (q.size() != 0 || wb_en !== 1'b0) begin
      bad++; $display("FAIL b_sb_empty got left=%0d en=%b want 0/0", q.size(), wb_en);
    end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    drive_b(5'd9, 64'h99); drive_a(5'd4, 64'h40); q.push_back('{5'd4, 64'h40});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      b_valid = 0;
      total++;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL starve_a_wins %0d got a_ready=%b want 1", i, a_ready); end
      drive_a(5'd4, 64'h40 + i); q.push_back('{5'd4, 64'h40 + i});
    end
    @(negedge clk);
    total++;
    if (a_ready !== 1'b0 || pending !== 32'h200) begin
      bad++; $display("FAIL starve_force got a_ready=%b pend=%h want 0/00000200", a_ready, pending);
    end
    drive_a(5'd4, 64'h44); q.push_back('{5'd9, 64'h99});
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || pending !== 32'd0) begin
      bad++; $display("FAIL starve_resume got a_ready=%b pend=%h want 1/0", a_ready, pending);
    end
    q.push_back('{5'd4, 64'h44});
    @(negedge clk);
    idle();
    @(negedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL starve_sb_empty got left=%0d want 0", q.size()); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive_b(5'd3, 64'h33); drive_a(5'd6, 64'h60); q.push_back('{5'd6, 64'h60});
    @(negedge clk);
    b_valid = 0;
    total++;
    if (pending !== 32'h8 || a_ready !== 1'b1) begin
      bad++; $display("FAIL x0_queued got pend=%h a_ready=%b want 00000008/1", pending, a_ready);
    end
    drive_a(5'd0, 64'hDEAD); q.push_back('{5'd3, 64'h33});
    @(negedge clk);
    total++;
    if (pending !== 32'd0 || b_ready !== 1'b1) begin
      bad++; $display("FAIL x0_a_drop got pend=%h b_ready=%b want 0/1", pending, b_ready);
    end
    a_valid = 0; drive_b(5'd0, 64'h5);
    @(negedge clk);
    idle();
    total++;
    if (fifo_count !== 3'd0 || pending !== 32'd0 || wb_en !== 1'b0) begin
      bad++; $display("FAIL x0_b_drop got cnt=%0d pend=%h en=%b want 0/0/0", fifo_count, pending, wb_en);
    end
    @(negedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL x0_sb_empty got left=%0d want 0", q.size()); end
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        total++;
        if (b2_ready !== 1'b0 || fifo_count2 !== 3'd4 || pending2 !== 32'h3C00) begin
          bad++; $display("FAIL full_after4 got ready=%b cnt=%0d pend=%h want 0/4/00003c00", b2_ready, fifo_count2, pending2);
        end
      end
      a2_valid = 1; a2_rd = 5'd1; a2_data = 64'h100 + i; q2.push_back('{5'd1, 64'h100 + i});
      b2_valid = 1; b2_rd = 5'(10 + i); b2_data = 64'hB0 + i;
    end
    @(negedge clk);
    total++;
    if (b2_ready !== 1'b0 || fifo_count2 !== 3'd4) begin
      bad++; $display("FAIL full_held got ready=%b cnt=%0d want 0/4", b2_ready, fifo_count2);
    end
    a2_valid = 0;
    for (int i = 0; i < 5; i++) q2.push_back('{5'(10 + i), 64'hB0 + i});
    @(negedge clk);
    total++;
    if (b2_ready !== 1'b1 || fifo_count2 !== 3'd3) begin
      bad++; $display("FAIL full_first_pop got ready=%b cnt=%0d want 1/3", b2_ready, fifo_count2);
    end
    @(negedge clk);
    b2_valid = 0;
    total++;
    if (fifo_count2 !== 3'd3) begin bad++; $display("FAIL full_push_pop got cnt=%0d want 3", fifo_count2); end
    repeat (3) @(negedge clk);
    total++;
    if (fifo_count2 !== 3'd0 || pending2 !== 32'd0) begin
      bad++; $display("FAIL full_drained got cnt=%0d pend=%h want 0/0", fifo_count2, pending2);
    end
    @(negedge clk);
    total++;
    if (q2.size() != 0) begin bad++; $display("FAIL full_sb_empty got left=%0d want 0", q2.size()); end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_only();
    test_starvation();
    test_x0();
    test_full_fifo();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
